// File: rtl/ram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram_pkg                                                      |
// | Description : Shared types and helpers for the ram_sdp_be RAM.            |
// |               - state_t     : clear-sequencer FSM state (ST_INIT/ST_IDLE) |
// |               - be_width()  : number of byte lanes in a data word         |
// |               - byte_merge(): per-byte merge, used for memory writes and  |
// |                               the read-during-write bypass                |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
package ram_pkg;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_IDLE = 1'b1
   } state_t;

   // byte_merge works on a fixed maximum width; callers zero-extend their
   // operands and truncate the result back to their own word width.
   localparam int MAX_DATA_WIDTH = 512;
   localparam int MAX_BE_WIDTH   = MAX_DATA_WIDTH / 8;

   function automatic int be_width(input int data_width);
      return data_width / 8;
   endfunction

   function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
      input logic [MAX_DATA_WIDTH-1:0] old_word,
      input logic [MAX_DATA_WIDTH-1:0] new_word,
      input logic [MAX_BE_WIDTH-1:0]   be
   );
      logic [MAX_DATA_WIDTH-1:0] merged;
      merged = old_word;
      for (int i = 0; i < MAX_BE_WIDTH; i++) begin
         if (be[i]) begin
            merged[8*i +: 8] = new_word[8*i +: 8];
         end
      end
      return merged;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ram_sdp_be_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram_sdp_be_if                                                |
// | Description : Bus interface of ram_sdp_be.                                 |
// |               master: drives clr, wr_en/wr_addr/wr_be/din, rd_en/rd_addr  |
// |               slave : drives dout, rd_valid, init_busy                    |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
interface ram_sdp_be_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 3
);
   import ram_pkg::*;

   localparam int BE_WIDTH = be_width(DATA_WIDTH);

   logic                  clr;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [BE_WIDTH-1:0]   wr_be;
   logic [DATA_WIDTH-1:0] din;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] dout;
   logic                  rd_valid;
   logic                  init_busy;

   modport master (
      output clr, wr_en, wr_addr, wr_be, din, rd_en, rd_addr,
      input  dout, rd_valid, init_busy
   );

   modport slave (
      input  clr, wr_en, wr_addr, wr_be, din, rd_en, rd_addr,
      output dout, rd_valid, init_busy
   );

endinterface
`default_nettype wire

// File: rtl/ram_clear_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram_clear_seq                                                |
// | Description : Clear sequencer for ram_sdp_be. Owns the INIT/IDLE FSM, the  |
// |               clear pointer and init_busy, and muxes either the clear     |
// |               write (INIT) or the user write (IDLE) onto the memory port. |
// | Ports       : clk, rst          - clock, synchronous active-high reset    |
// |               i_clr             - restart the clear sequence              |
// |               i_wr_*            - user write port                         |
// |               o_mem_*           - muxed memory write port                 |
// |               o_rd_ok           - reads may be accepted this cycle        |
// |               o_init_busy       - clear sequence in progress              |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module ram_clear_seq
   import ram_pkg::*;
#(
   parameter int                    DATA_WIDTH = 16,
   parameter int                    ADDR_WIDTH = 3,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  wire logic                               clk,
   input  wire logic                               rst,
   input  wire logic                               i_clr,
   input  wire logic                               i_wr_en,
   input  wire logic [ADDR_WIDTH-1:0]              i_wr_addr,
   input  wire logic [be_width(DATA_WIDTH)-1:0]    i_wr_be,
   input  wire logic [DATA_WIDTH-1:0]              i_din,
   output logic                                    o_mem_we,
   output logic      [ADDR_WIDTH-1:0]              o_mem_addr,
   output logic      [be_width(DATA_WIDTH)-1:0]    o_mem_be,
   output logic      [DATA_WIDTH-1:0]              o_mem_data,
   output logic                                    o_rd_ok,
   output logic                                    o_init_busy
);

   localparam logic [ADDR_WIDTH-1:0] c_last_addr = '1;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_ptr;
   logic                  r_busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_INIT;
         r_ptr   <= '0;
         r_busy  <= 1'b1;
      end else begin
         case (r_state)
            ST_INIT: begin
               if (i_clr) begin
                  r_ptr <= '0;
               end else if (r_ptr == c_last_addr) begin
                  r_state <= ST_IDLE;
                  r_ptr   <= '0;
                  r_busy  <= 1'b0;
               end else begin
                  r_ptr <= r_ptr + 1'b1;
               end
            end
            ST_IDLE: begin
               if (i_clr) begin
                  r_state <= ST_INIT;
                  r_ptr   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_INIT;
               r_ptr   <= '0;
               r_busy  <= 1'b1;
            end
         endcase
      end
   end

   // Nothing is written while rst is held, so the clear sequence always
   // starts from a quiet memory. A clr in IDLE drops the coincident write.
   always_comb begin
      o_mem_we   = 1'b0;
      o_mem_addr = i_wr_addr;
      o_mem_be   = i_wr_be;
      o_mem_data = i_din;
      if (r_state == ST_INIT) begin
         o_mem_we   = ~rst;
         o_mem_addr = r_ptr;
         o_mem_be   = '1;
         o_mem_data = INIT_VALUE;
      end else begin
         o_mem_we   = i_wr_en & ~i_clr & ~rst;
      end
   end

   assign o_rd_ok     = (r_state == ST_IDLE);
   assign o_init_busy = r_busy;

endmodule
`default_nettype wire

// File: rtl/ram_sdp_be.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram_sdp_be                                                   |
// | Description : Simple-dual-port synchronous RAM with byte-enabled write,   |
// |               flagged read and a built-in clear sequencer.                |
// | Ports       : clk, rst - clock, synchronous active-high reset             |
// |               bus      - ram_sdp_be_if.slave (clr, write port, read port, |
// |                          dout, rd_valid, init_busy)                       |
// | Parameters  : DATA_WIDTH (multiple of 8), ADDR_WIDTH, RDW_MODE            |
// |               (0 = old data, 1 = byte-merged new data), INIT_VALUE        |
// | Macro       : RAM_SDP_OUT_REG_EN adds an output register stage            |
// |               (read latency 2 instead of 1).                              |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module ram_sdp_be
   import ram_pkg::*;
#(
   parameter int                    DATA_WIDTH = 16,
   parameter int                    ADDR_WIDTH = 3,
   parameter int                    RDW_MODE   = 0,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input wire logic   clk,
   input wire logic   rst,
   ram_sdp_be_if.slave bus
);

   localparam int DEPTH    = 2 ** ADDR_WIDTH;
   localparam int BE_WIDTH = be_width(DATA_WIDTH);

   logic                  w_mem_we;
   logic [ADDR_WIDTH-1:0] w_mem_addr;
   logic [BE_WIDTH-1:0]   w_mem_be;
   logic [DATA_WIDTH-1:0] w_mem_data;
   logic                  w_rd_ok;
   logic                  w_rd_accept;
   logic                  w_bypass;
   logic [DATA_WIDTH-1:0] w_rd_word;
   logic [DATA_WIDTH-1:0] w_rd_data;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_dout1;
   logic                  r_valid1;

   ram_clear_seq #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .INIT_VALUE (INIT_VALUE)
   ) u_clear_seq (
      .clk         (clk),
      .rst         (rst),
      .i_clr       (bus.clr),
      .i_wr_en     (bus.wr_en),
      .i_wr_addr   (bus.wr_addr),
      .i_wr_be     (bus.wr_be),
      .i_din       (bus.din),
      .o_mem_we    (w_mem_we),
      .o_mem_addr  (w_mem_addr),
      .o_mem_be    (w_mem_be),
      .o_mem_data  (w_mem_data),
      .o_rd_ok     (w_rd_ok),
      .o_init_busy (bus.init_busy)
   );

   // Memory array: read-modify-write of the addressed word, only the enabled
   // byte lanes change.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_addr] <= DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(r_mem[w_mem_addr]),
                                                     MAX_DATA_WIDTH'(w_mem_data),
                                                     MAX_BE_WIDTH'(w_mem_be)));
      end
   end

   assign w_rd_accept = bus.rd_en & w_rd_ok;
   assign w_rd_word   = r_mem[bus.rd_addr];

   // In new-data mode a same-address write in the same cycle is forwarded
   // through the same byte merge the array itself applies.
   assign w_bypass  = (RDW_MODE == 1) && w_mem_we && w_rd_accept &&
                      (w_mem_addr == bus.rd_addr);
   assign w_rd_data = w_bypass ?
                      DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(w_rd_word),
                                             MAX_DATA_WIDTH'(w_mem_data),
                                             MAX_BE_WIDTH'(w_mem_be))) :
                      w_rd_word;

   // dout only changes on an accepted read; otherwise it holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dout1  <= '0;
         r_valid1 <= 1'b0;
      end else begin
         r_valid1 <= w_rd_accept;
         if (w_rd_accept) begin
            r_dout1 <= w_rd_data;
         end
      end
   end

`ifdef RAM_SDP_OUT_REG_EN
   logic [DATA_WIDTH-1:0] r_dout2;
   logic                  r_valid2;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_dout2  <= '0;
         r_valid2 <= 1'b0;
      end else begin
         r_valid2 <= r_valid1;
         if (r_valid1) begin
            r_dout2 <= r_dout1;
         end
      end
   end

   assign bus.dout     = r_dout2;
   assign bus.rd_valid = r_valid2;
`else
   assign bus.dout     = r_dout1;
   assign bus.rd_valid = r_valid1;
`endif

endmodule
`default_nettype wire
